// File: rtl/car_speed_ctrl_pkg.sv
// Shared speed encoding for the car speed controller.
// Optional status pulses are enabled with the CAR_SPEED_STATUS_EN macro.
package car_speed_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    SLOW   = 2'd1,
    MEDIUM = 2'd2,
    FAST   = 2'd3
  } speed_t;

  localparam speed_t SPEED_MIN = STOP;
  localparam speed_t SPEED_MAX = FAST;

endpackage

// File: rtl/car_speed_ctrl_if.sv
// Driver-input / speed-output bundle between input conditioning and the controller.
// Status pulse signals exist only when CAR_SPEED_STATUS_EN is defined.
interface car_speed_ctrl_if
  import car_speed_pkg::*;
  ();

  logic   keys;
  logic   brake;
  logic   accelerate;
  speed_t speed;
`ifdef CAR_SPEED_STATUS_EN
  logic   speed_up;
  logic   speed_down;
`endif

  modport master (
    output keys,
    output brake,
    output accelerate,
`ifdef CAR_SPEED_STATUS_EN
    input  speed_up,
    input  speed_down,
`endif
    input  speed
  );

  modport slave (
    input  keys,
    input  brake,
    input  accelerate,
`ifdef CAR_SPEED_STATUS_EN
    output speed_up,
    output speed_down,
`endif
    output speed
  );

endinterface

// File: rtl/car_speed_ctrl_next.sv
// Combinational next-speed function: key-off, then brake, then accelerate, else hold.
module car_speed_next
  import car_speed_pkg::*;
  (
    input  logic   keys,
    input  logic   brake,
    input  logic   accelerate,
    input  speed_t speed_cur,
    output speed_t speed_nxt
  );

  always_comb begin
    speed_nxt = speed_cur;
    if (!keys) begin
      speed_nxt = SPEED_MIN;
    end else if (brake) begin
      // Brake wins over accelerate; floor saturates at STOP.
      if (speed_cur != SPEED_MIN) speed_nxt = speed_t'(speed_cur - 2'd1);
    end else if (accelerate) begin
      if (speed_cur != SPEED_MAX) speed_nxt = speed_t'(speed_cur + 2'd1);
    end
  end

endmodule

// File: rtl/car_speed_ctrl.sv
// Car speed controller top: speed register with synchronous reset.
// Define CAR_SPEED_STATUS_EN to add registered speed_up/speed_down pulses.
module car_speed_ctrl
  import car_speed_pkg::*;
  (
    input  logic             clock,
    input  logic             reset,
    car_speed_ctrl_if.slave  bus
  );

  speed_t speed_reg;
  speed_t speed_next;

  car_speed_next u_next (
    .keys       (bus.keys),
    .brake      (bus.brake),
    .accelerate (bus.accelerate),
    .speed_cur  (speed_reg),
    .speed_nxt  (speed_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      speed_reg <= STOP;
    end else begin
      speed_reg <= speed_next;
    end
  end

  assign bus.speed = speed_reg;

`ifdef CAR_SPEED_STATUS_EN
  logic up_reg;
  logic down_reg;

  // Pulses reflect the change made on the same edge; saturation/hold compare equal.
  always_ff @(posedge clock) begin
    if (reset) begin
      up_reg   <= 1'b0;
      down_reg <= 1'b0;
    end else begin
      up_reg   <= (speed_next > speed_reg);
      down_reg <= (speed_next < speed_reg);
    end
  end

  assign bus.speed_up   = up_reg;
  assign bus.speed_down = down_reg;
`endif

endmodule

// File: tb/tb_car_speed_ctrl.sv
// Self-checking bench for car_speed_ctrl: directed plan plus random stimulus vs a behavioural model.
module tb_car_speed_ctrl;
  import car_speed_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  car_speed_ctrl_if bus ();

  car_speed_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int model = 0;
  bit up_m  = 1'b0;
  bit dn_m  = 1'b0;
  bit chk_en = 1'b0;

  // One clock edge with the given inputs; model follows the rules as plain arithmetic.
  task automatic step(input logic r, input logic k, input logic b, input logic a);
    int prev;
    reset = r;
    bus.keys = k;
    bus.brake = b;
    bus.accelerate = a;
    @(posedge clock);
    prev = model;
    if (r) begin
      model = 0;
      up_m = 1'b0;
      dn_m = 1'b0;
    end else begin
      if (!k)      model = 0;
      else if (b)  model = (model > 0) ? model - 1 : 0;
      else if (a)  model = (model < 3) ? model + 1 : 3;
      up_m = (model > prev);
      dn_m = (model < prev);
    end
    @(negedge clock);
  endtask

  // Step and check the DUT speed against a hand-computed literal.
  task automatic go(input logic r, input logic k, input logic b, input logic a,
                    input int e, input string nm);
    step(r, k, b, a);
    tests++;
    if (bus.speed !== 2'(e)) begin
      fails++;
      $display("FAIL %s speed=%0d expected=%0d", nm, bus.speed, e);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      tests++;
      if (bus.speed !== 2'(model)) begin
        fails++;
        $display("FAIL cycle_speed t=%0t speed=%0d expected=%0d", $time, bus.speed, model);
      end
`ifdef CAR_SPEED_STATUS_EN
      tests++;
      if (bus.speed_up !== up_m || bus.speed_down !== dn_m) begin
        fails++;
        $display("FAIL cycle_pulse t=%0t up=%b down=%b expected up=%b down=%b",
                 $time, bus.speed_up, bus.speed_down, up_m, dn_m);
      end
`endif
    end
  end

  initial begin
    reset = 1'b1;
    bus.keys = 1'b0;
    bus.brake = 1'b0;
    bus.accelerate = 1'b1;
    chk_en = 1'b1;

    // Reset with accelerate, then key off with accelerate
    go(1, 0, 0, 1, 0, "reset_accel");
    go(1, 0, 0, 1, 0, "reset_accel");
    repeat (3) go(0, 0, 0, 1, 0, "keys_off_accel");

    // Accelerate to FAST and saturate
    go(0, 1, 0, 1, 1, "accel_1");
    go(0, 1, 0, 1, 2, "accel_2");
    go(0, 1, 0, 1, 3, "accel_3");
    go(0, 1, 0, 1, 3, "accel_sat");

    // Brake priority and floor saturation
    go(0, 1, 1, 1, 2, "brake_prio_2");
    go(0, 1, 1, 1, 1, "brake_prio_1");
    go(0, 1, 1, 1, 0, "brake_prio_0");
    go(0, 1, 1, 0, 0, "brake_floor");

    // Mixed sequence from STOP
    go(0, 1, 0, 1, 1, "seq_a1");
    go(0, 1, 0, 1, 2, "seq_a2");
    go(0, 1, 1, 0, 1, "seq_b1");
    go(0, 1, 1, 1, 0, "seq_ba");
    go(0, 1, 0, 1, 1, "seq_a3");
    go(0, 1, 0, 0, 1, "seq_idle");
    go(0, 1, 0, 1, 2, "seq_a4");
    go(0, 1, 0, 1, 3, "seq_a5");
    go(0, 1, 0, 1, 3, "seq_a6");
    go(0, 1, 1, 0, 2, "seq_b2");
    go(0, 1, 1, 0, 1, "seq_b3");
    go(0, 1, 1, 0, 0, "seq_b4");

    // Key drop from FAST
    repeat (3) step(0, 1, 0, 1);
    go(0, 0, 0, 0, 0, "key_drop");
    go(0, 1, 0, 0, 0, "key_back_idle");

    // Reset mid-operation at MEDIUM with accelerate
    step(0, 1, 0, 1);
    go(0, 1, 0, 1, 2, "pre_reset_2");
    go(1, 1, 0, 1, 0, "reset_mid");

    // Random stimulus checked by the compare process
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
